aq_f_spsram_arb_ctrl: RTL

//  Shares one 1024x64 single-port SRAM macro wrapper between two requesters. Per cycle it

---
 rtl/aq_f_spsram_arb_ctrl_pkg.sv | 14 +
 rtl/aq_f_spsram_rr_arb2.sv | 41 ++++
 rtl/aq_f_spsram_arb_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aq_f_spsram_arb_ctrl_pkg.sv
// Shared types for the single-port SRAM arbiter/controller.
// FSM encoding and byte-enable width derivation.
package aq_f_spsram_arb_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/aq_f_spsram_rr_arb2.sv
// Two-way round-robin arbiter.
// Owns the priority pointer; pointer flips away from each winner.
module aq_f_spsram_rr_arb2 (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       en,
  input  logic [1:0] vld,
  output logic [1:0] gnt,
  output logic       rr_ptr
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt      = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      unique case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    if (|gnt) begin
      rr_ptr_d = gnt[0];
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/aq_f_spsram_arb_ctrl.sv
// Two-requester front end for a single-port SRAM wrapper.
// Round-robin access, one-cycle read return, zero-fill init sweep.
module aq_f_spsram_arb_ctrl
  import aq_f_spsram_arb_ctrl_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 10,
  parameter int  DATA_WIDTH  = 64,
  parameter bit  INIT_ON_RST = 1'b1,
  localparam int BE_WIDTH    = be_width(DATA_WIDTH)
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [BE_WIDTH-1:0]   req0_be,
  output logic                  req0_rvld,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [BE_WIDTH-1:0]   req1_be,
  output logic                  req1_rvld,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam state_e RST_ST = state_e'(INIT_ON_RST);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic [ADDR_WIDTH-1:0] init_cnt_d;
  logic [1:0]            rd_own_q;
  logic [1:0]            rd_own_d;

  logic                  arb_en;
  logic [1:0]            gnt;
  logic                  rr_ptr;

  logic [DATA_WIDTH-1:0] wen0;
  logic [DATA_WIDTH-1:0] wen1;

  logic [ADDR_WIDTH-1:0] pin_a;
  logic                  pin_cen;
  logic [DATA_WIDTH-1:0] pin_d;
  logic                  pin_gwen;
  logic [DATA_WIDTH-1:0] pin_wen;

  assign arb_en = (state_q == ST_IDLE) & ~init_req;

  aq_f_spsram_rr_arb2 u_arb (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .en             (arb_en),
    .vld            ({req1_vld, req0_vld}),
    .gnt            (gnt),
    .rr_ptr         (rr_ptr)
  );

  always_comb begin
    wen0 = '0;
    wen1 = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      wen0[8*i +: 8] = {8{req0_be[i]}};
      wen1[8*i +: 8] = {8{req1_be[i]}};
    end
  end

  always_comb begin
    pin_a    = '0;
    pin_cen  = 1'b1;
    pin_d    = '0;
    pin_gwen = 1'b0;
    pin_wen  = '0;
    unique case (1'b1)
      (state_q == ST_INIT): begin
        pin_a    = init_cnt_q;
        pin_cen  = 1'b0;
        pin_gwen = 1'b1;
        pin_wen  = '1;
      end
      gnt[0]: begin
        pin_a    = req0_addr;
        pin_cen  = 1'b0;
        pin_d    = req0_wdata;
        pin_gwen = req0_wr;
        pin_wen  = req0_wr ? wen0 : '0;
      end
      gnt[1]: begin
        pin_a    = req1_addr;
        pin_cen  = 1'b0;
        pin_d    = req1_wdata;
        pin_gwen = req1_wr;
        pin_wen  = req1_wr ? wen1 : '0;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rd_own_d   = {gnt[1] & ~req1_wr, gnt[0] & ~req0_wr};
    unique case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (&init_cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= RST_ST;
      init_cnt_q <= '0;
      rd_own_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_own_q   <= rd_own_d;
    end
  end

  // Reset gates the pins directly so the macro sees an idle bus
  // while held in reset, even though the FSM already sits in INIT.
  assign sram_a    = pin_a & {ADDR_WIDTH{cpurst_b}};
  assign sram_cen  = pin_cen | ~cpurst_b;
  assign sram_d    = pin_d & {DATA_WIDTH{cpurst_b}};
  assign sram_gwen = pin_gwen & cpurst_b;
  assign sram_wen  = pin_wen & {DATA_WIDTH{cpurst_b}};

  assign req0_rdy  = gnt[0] & cpurst_b & ~rr_ptr | gnt[0] & cpurst_b & rr_ptr;
  assign req1_rdy  = gnt[1] & cpurst_b;

  assign req0_rvld  = rd_own_q[0];
  assign req1_rvld  = rd_own_q[1];
  assign req0_rdata = sram_q;
  assign req1_rdata = sram_q;

  assign init_busy = (state_q == ST_INIT);

endmodule
